program_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the processor's program memory. It receives a framed instruction image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them sequentially into program memory. It holds the processor core in reset until a complete, checksum-verified image has been written.

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream receive and program-memory write bundle for program_loader.
// The master side feeds bytes; the slave side (the loader) drives memory and status.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  pm_we;
  logic [ADDR_WIDTH-1:0] pm_addr;
  logic [31:0]           pm_wdata;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pm_we, pm_addr, pm_wdata, cpu_reset, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pm_we, pm_addr, pm_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Framed boot loader: assembles big-endian words into program memory and holds the core
// in reset until the image is complete. Define PROGRAM_LOADER_CHECKSUM_EN for the checksum byte.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH   = 5
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned ASM_W   = 24;
  localparam logic [7:0]  HEADER  = 8'hA5;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
  } state_t;
`endif

  state_t                state;
  logic [LEN_W-1:0]      wordCount;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0]            byteIdx;
  logic [ASM_W-1:0]      assembly;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            xorAcc;
`endif

  logic                  rxReadyC;
  logic                  byteFireC;
  logic                  isHeaderC;
  logic                  lastWordC;
  logic [LEN_W-1:0]      newCountC;

  // Ready only depends on reset and state so the source never sees a handshake loop.
  assign rxReadyC     = !reset && (state != WRITE);
  assign bus.rx_ready = rxReadyC;
  assign byteFireC    = bus.rx_valid && rxReadyC;
  assign isHeaderC    = (bus.rx_data == HEADER);
  assign newCountC    = {wordCount[LEN_W-1:8], bus.rx_data};
  assign lastWordC    = (LEN_W'(wordIdx) == (wordCount - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wordCount     <= '0;
      wordIdx       <= '0;
      byteIdx       <= '0;
      assembly      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xorAcc        <= '0;
`endif
      bus.pm_we     <= 1'b0;
      bus.pm_addr   <= '0;
      bus.pm_wdata  <= '0;
      bus.cpu_reset <= 1'b1;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.pm_we <= 1'b0;
      unique case (state)
        // Non-header bytes are swallowed; a header restarts from any resting state.
        IDLE, DONE, ERROR: begin
          if (byteFireC && isHeaderC) begin
            bus.cpu_reset <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            wordIdx       <= '0;
            byteIdx       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorAcc        <= '0;
`endif
            state         <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byteFireC) begin
            wordCount[LEN_W-1:8] <= bus.rx_data;
            state                <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (byteFireC) begin
            wordCount <= newCountC;
            if (newCountC > LEN_W'(MEMORY_DEPTH)) begin
              bus.error <= 1'b1;
              state     <= ERROR;
            end else if (newCountC == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state         <= CHECK;
`else
              bus.done      <= 1'b1;
              bus.cpu_reset <= 1'b0;
              state         <= DONE;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (byteFireC) begin
            assembly <= {assembly[ASM_W-9:0], bus.rx_data};
            byteIdx  <= byteIdx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xorAcc   <= xorAcc ^ bus.rx_data;
`endif
            if (byteIdx == 2'd3) begin
              bus.pm_we    <= 1'b1;
              bus.pm_addr  <= wordIdx;
              bus.pm_wdata <= {assembly, bus.rx_data};
              state        <= WRITE;
            end
          end
        end
        // The index stays on the last word so it never passes count-1.
        WRITE: begin
          if (lastWordC) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state         <= CHECK;
`else
            bus.done      <= 1'b1;
            bus.cpu_reset <= 1'b0;
            state         <= DONE;
`endif
          end else begin
            wordIdx <= wordIdx + ADDR_WIDTH'(1);
            state   <= DATA;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (byteFireC) begin
            if (bus.rx_data == xorAcc) begin
              bus.done      <= 1'b1;
              bus.cpu_reset <= 1'b0;
              state         <= DONE;
            end else begin
              bus.error <= 1'b1;
              state     <= ERROR;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes expected writes/status derived from
// the frame rules, and a negedge monitor pops and compares them when they fall due.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [31:0] data; int at; } wr_t;
  typedef struct { bit dn; bit er; bit cpuRst; int at; } st_t;

  wr_t        wrQ[$];
  st_t        stQ[$];
  logic [7:0] payload[$];
  int         total   = 0;
  int         bad     = 0;
  int         lastAcc = 0;
  bit         monOn   = 1'b0;
  bit         prevTerm = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic pushStatus(input bit dn, input bit er, input bit cr, input int at);
    st_t s;
    s.dn = dn; s.er = er; s.cpuRst = cr; s.at = at;
    stQ.push_back(s);
  endtask

  // Offers one byte from a negedge and holds it until a rising edge accepts it.
  task automatic sendByte(input logic [7:0] b);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!acc && guard < 100) begin
      acc = bus.rx_ready;
      @(posedge clk);
      guard++;
      if (!acc) @(negedge clk);
    end
    #1;
    bus.rx_valid = 1'b0;
    lastAcc = cyc;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hA5;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pm_we",     bus.pm_we,     0);
    check("rst_pm_addr",   bus.pm_addr,   0);
    check("rst_pm_wdata",  bus.pm_wdata,  0);
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_done",      bus.done,      0);
    check("rst_error",     bus.error,     0);
    check("rst_rx_ready",  bus.rx_ready,  0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Sends a frame built from payload[]; abortAfter >= 0 resets after that many payload bytes.
  task automatic sendFrame(input logic [15:0] cnt, input bit badChk, input int gapPct,
                           input int abortAfter);
    logic [7:0] chk;
    wr_t        w;
    chk = 8'h00;
    sendByte(8'hA5);
    @(negedge clk);
    check("hdr_cpu_reset", bus.cpu_reset, 1);
    check("hdr_done",      bus.done,      0);
    check("hdr_error",     bus.error,     0);
    sendByte(cnt[15:8]);
    if ($urandom_range(99) < gapPct) idle($urandom_range(1, 3));
    sendByte(cnt[7:0]);
    if (int'(cnt) > int'(DEPTH)) begin
      pushStatus(1'b0, 1'b1, 1'b1, lastAcc);
      return;
    end
    for (int i = 0; i < int'(cnt) * 4; i++) begin
      if (i == abortAfter) begin
        doReset();
        return;
      end
      if ($urandom_range(99) < gapPct) idle($urandom_range(1, 3));
      sendByte(payload[i]);
      chk = chk ^ payload[i];
      if (i % 4 == 3) begin
        w.addr = i / 4;
        w.data = (32'(payload[i-3]) << 24) + (32'(payload[i-2]) << 16) +
                 (32'(payload[i-1]) << 8) + 32'(payload[i]);
        w.at   = lastAcc;
        wrQ.push_back(w);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendByte(badChk ? ~chk : chk);
    if (badChk) pushStatus(1'b0, 1'b1, 1'b1, lastAcc);
    else        pushStatus(1'b1, 1'b0, 1'b0, lastAcc);
`else
    if (badChk) begin end
    pushStatus(1'b1, 1'b0, 1'b0, (cnt == 16'd0) ? lastAcc : lastAcc + 1);
`endif
  endtask

  task automatic randPayload(input int nWords);
    payload.delete();
    for (int i = 0; i < nWords * 4; i++) payload.push_back(8'($urandom));
  endtask

  // Monitor: every output event must coincide with a queued expectation.
  always @(negedge clk) begin
    bit  expWr;
    bit  expSt;
    bit  term;
    wr_t w;
    st_t s;
    if (monOn) begin
      expWr = (wrQ.size() > 0) && (wrQ[0].at == cyc);
      check("pm_we", bus.pm_we, expWr);
      check("rx_ready", bus.rx_ready, !reset && !expWr);
      if (expWr) begin
        w = wrQ.pop_front();
        check("pm_addr",  bus.pm_addr,  w.addr);
        check("pm_wdata", bus.pm_wdata, w.data);
      end
      expSt = (stQ.size() > 0) && (stQ[0].at == cyc);
      term  = bus.done | bus.error;
      if (expSt) begin
        s = stQ.pop_front();
        check("done",      bus.done,      s.dn);
        check("error",     bus.error,     s.er);
        check("cpu_reset", bus.cpu_reset, s.cpuRst);
      end else if (term && !prevTerm) begin
        check("unexpected_status", term, 0);
      end
      prevTerm = term;
    end
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_pm_we",     bus.pm_we,     0);
    check("init_pm_addr",   bus.pm_addr,   0);
    check("init_pm_wdata",  bus.pm_wdata,  0);
    check("init_cpu_reset", bus.cpu_reset, 1);
    check("init_done",      bus.done,      0);
    check("init_error",     bus.error,     0);
    check("init_rx_ready",  bus.rx_ready,  0);
    @(posedge clk);
    #1 reset = 1'b0;
    monOn = 1'b1;

    // Reference 2-word frame, good then corrupted checksum.
    payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    sendFrame(16'd2, 1'b0, 0, -1);
    sendFrame(16'd2, 1'b1, 0, -1);

    // Count one past the memory depth.
    sendFrame(16'h0021, 1'b0, 0, -1);

    // Garbage before the header and idle gaps inside words.
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h5A);
    sendFrame(16'd2, 1'b0, 60, -1);

    // Reset after 6 payload bytes, then a clean 1-word load, then a reload after DONE.
    randPayload(2);
    sendFrame(16'd2, 1'b0, 0, 6);
    randPayload(1);
    sendFrame(16'd1, 1'b0, 0, -1);
    randPayload(1);
    sendFrame(16'd1, 1'b0, 20, -1);

    // Boundary counts: empty image and full memory.
    sendFrame(16'd0, 1'b0, 0, -1);
    randPayload(int'(DEPTH));
    sendFrame(16'(DEPTH), 1'b0, 10, -1);

    for (int f = 0; f < 20; f++) begin
      int          r;
      logic [15:0] cnt;
      int          abortAt;
      r = $urandom_range(99);
      if (r < 12) cnt = 16'($urandom_range(int'(DEPTH) + 1, 700));
      else        cnt = 16'($urandom_range(0, int'(DEPTH)));
      abortAt = -1;
      if (cnt != 16'd0 && int'(cnt) <= int'(DEPTH) && $urandom_range(99) < 10)
        abortAt = $urandom_range(0, int'(cnt) * 4 - 1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        sendByte(gb);
      end
      randPayload(int'(cnt) <= int'(DEPTH) ? int'(cnt) : 0);
      sendFrame(cnt, $urandom_range(99) < 25, $urandom_range(0, 40), abortAt);
    end

    for (int k = 0; k < 20 && (wrQ.size() > 0 || stQ.size() > 0); k++) @(posedge clk);
    @(negedge clk);
    check("drain_writes", wrQ.size(), 0);
    check("drain_status", stQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
